regfile_dump_ctrl: RTL and testbench

- Debug controller that sequences the register file's debug read port. On request it walks registers 0..NREGS-1 and captures each 32-bit word.
- Each word is streamed MSB byte first to a UART transmitter through a start/done handshake.
- Sits between the debug unit (start/abort, busy/done) and the register file plus UART TX. Holds Debug_on high for the whole dump; the top level stalls the pipeline while busy=1.

---
 rtl/debug_pkg.sv | 21 ++
 rtl/word_serializer.sv | 53 +++++
 rtl/regfile_dump_ctrl.sv | 142 ++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the debug register-dump path.
package debug_pkg;

  localparam int unsigned DEF_NREGS      = 32;
  localparam int unsigned DEF_ADDR_W     = 5;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_READ_LAT   = 1;
  localparam int unsigned BYTES_PER_WORD = DEF_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    WAIT_RD,
    LOAD,
    SEND,
    WAIT_TX,
    NEXT,
    DONE
  } dump_state_e;

endpackage

// File: rtl/word_serializer.sv
// Holds one captured register word and emits it MSB byte first, one byte per
// tx_start pulse; last_c flags the final byte of the word.
module word_serializer
  import debug_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              send,
  input  logic              shift,
  input  logic [DATA_W-1:0] word,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              last_c
);

  localparam int unsigned BPW   = DATA_W / 8;
  localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  byte_cnt;

  assign last_c = (byte_cnt == CNT_W'(BPW - 1));

  // Shift register, byte counter and the registered UART request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= send;
      if (send) tx_data <= shreg[DATA_W-1 -: 8];
      if (load) begin
        shreg    <= word;
        byte_cnt <= '0;
      end else if (shift) begin
        shreg    <= shreg << 8;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file debug port over all registers and streams every
// word to the UART transmitter; busy stalls the pipeline for the whole dump.
module regfile_dump_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned READ_LAT = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_abort,
  input  logic [DATA_W-1:0] regDebug_in,
  input  logic              tx_done,
  output logic              debug_on,
  output logic [ADDR_W-1:0] read_regDebug,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  dump_state_e       state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt, addr_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic              load, send, shift, clr, last_c;
  logic              debug_on_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Register walk; a byte is accepted only once its own tx_start has gone by.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    lat_nxt   = lat_cnt;
    addr_nxt  = read_regDebug;
    load      = 1'b0;
    send      = 1'b0;
    shift     = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start && !dump_abort) begin
          state_nxt = SET_ADDR;
          idx_nxt   = '0;
        end
      end
      SET_ADDR: begin
        addr_nxt  = idx;
        lat_nxt   = '0;
        state_nxt = WAIT_RD;
      end
      WAIT_RD: begin
        lat_nxt = lat_cnt + 1'b1;
        if (lat_cnt == LAT_W'(READ_LAT - 1)) begin
          lat_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        send      = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done && !tx_start) begin
          shift     = 1'b1;
          state_nxt = last_c ? NEXT : SEND;
        end
      end
      NEXT: begin
        if (idx == ADDR_W'(NREGS - 1)) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = SET_ADDR;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort overrides everything, including a tx_done in the same cycle.
    if (dump_abort && (state != IDLE)) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      lat_nxt   = '0;
      addr_nxt  = '0;
      load      = 1'b0;
      send      = 1'b0;
      shift     = 1'b0;
      clr       = 1'b1;
    end

    debug_on_nxt = state_nxt inside {SET_ADDR, WAIT_RD, LOAD, SEND, WAIT_TX, NEXT};
    done_nxt     = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx           <= '0;
      lat_cnt       <= '0;
      read_regDebug <= '0;
      debug_on      <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      idx           <= idx_nxt;
      lat_cnt       <= lat_nxt;
      read_regDebug <= addr_nxt;
      debug_on      <= debug_on_nxt;
      done          <= done_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

  word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .send     (send),
    .shift    (shift),
    .word     (regDebug_in),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .last_c   (last_c)
  );

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: a 1-cycle and a 2-cycle read-latency
// instance, a shared UART responder, and a monitor that pops expected bytes.
module tb_regfile_dump_ctrl;

  typedef struct packed {
    logic [7:0] b;
    logic [4:0] idx;
  } exp_t;

  logic        clk, rst;
  logic        dump_start, dump_abort, start2, abort2, tx_done, kick, stretch;
  logic [31:0] regDebug_in, regDebug_in2, p1;
  logic        debug_on, debug_on2, tx_start, tx_start2, busy, busy2, done, done2;
  logic [4:0]  read_regDebug, read_regDebug2;
  logic [7:0]  tx_data, tx_data2;

  logic [31:0] rf [32];
  exp_t        q1[$];
  exp_t        q2[$];
  int          n_checks = 0, n_pass = 0;
  int          n_bytes = 0, n_bytes2 = 0, n_done = 0, n_done2 = 0;
  int          glitch = 0, glitch2 = 0;
  bit          chk_busy1 = 0, chk_busy2 = 0;

  regfile_dump_ctrl u_dut (
    .clk (clk), .rst (rst), .dump_start (dump_start), .dump_abort (dump_abort),
    .regDebug_in (regDebug_in), .tx_done (tx_done), .debug_on (debug_on),
    .read_regDebug (read_regDebug), .tx_data (tx_data), .tx_start (tx_start),
    .busy (busy), .done (done)
  );

  regfile_dump_ctrl #(.READ_LAT(2)) u_dut2 (
    .clk (clk), .rst (rst), .dump_start (start2), .dump_abort (abort2),
    .regDebug_in (regDebug_in2), .tx_done (tx_done), .debug_on (debug_on2),
    .read_regDebug (read_regDebug2), .tx_data (tx_data2), .tx_start (tx_start2),
    .busy (busy2), .done (done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file contents; reg0, reg5 and reg31 carry the documented values.
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {8'(i), 8'hA5, 8'(3 * i), 8'(i + 1)};
    rf[0]  = 32'h0000_0001;
    rf[5]  = 32'h0000_0015;
    rf[31] = 32'h0000_002A;
  end

  // Read port reading on negedge (1 cycle), and a 2-cycle pipelined variant.
  always @(negedge clk) regDebug_in <= rf[read_regDebug];
  always @(posedge clk) begin
    p1           <= rf[read_regDebug2];
    regDebug_in2 <= p1;
  end

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endfunction

  function automatic void push_dump(input int nfull, input int nextra, input int which);
    logic [31:0] w;
    exp_t        e;
    for (int r = 0; r <= nfull; r++) begin
      w = rf[r];
      for (int b = 0; b < ((r < nfull) ? 4 : nextra); b++) begin
        e.b   = w[31 - 8 * b -: 8];
        e.idx = 5'(r);
        if (which == 1) q1.push_back(e);
        else            q2.push_back(e);
      end
    end
  endfunction

  // UART model: tx_done 10 cycles after tx_start; stretched to 3 cycles on request.
  initial begin
    int pend, hold;
    pend = 0; hold = 0; tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = kick;
      if (hold > 0) begin tx_done = 1'b1; hold--; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin tx_done = 1'b1; hold = stretch ? 2 : 0; end
      end
      if (tx_start || tx_start2) pend = 9;
    end
  end

  // Monitor: pops the scoreboard on every byte and tracks done/busy/debug_on.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_busy1) begin check(busy == 1'b0, "busy_after_done", 32'(busy), 0); chk_busy1 = 0; end
      if (chk_busy2) begin check(busy2 == 1'b0, "busy2_after_done", 32'(busy2), 0); chk_busy2 = 0; end
      if (tx_start) begin
        n_bytes++;
        check(q1.size() > 0, "byte_expected", 32'(q1.size()), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check(tx_data == e.b, "tx_data", 32'(tx_data), 32'(e.b));
          check(read_regDebug == e.idx, "byte_addr", 32'(read_regDebug), 32'(e.idx));
          check(debug_on == 1'b1, "debug_on_tx", 32'(debug_on), 1);
        end
      end
      if (tx_start2) begin
        n_bytes2++;
        check(q2.size() > 0, "byte2_expected", 32'(q2.size()), 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          check(tx_data2 == e.b, "tx_data2", 32'(tx_data2), 32'(e.b));
          check(read_regDebug2 == e.idx, "byte2_addr", 32'(read_regDebug2), 32'(e.idx));
        end
      end
      if (done) begin
        n_done++;
        check(q1.size() == 0, "done_after_last", 32'(q1.size()), 0);
        check(busy == 1'b1, "busy_at_done", 32'(busy), 1);
        chk_busy1 = 1;
      end
      if (done2) begin
        n_done2++;
        check(q2.size() == 0, "done2_after_last", 32'(q2.size()), 0);
        chk_busy2 = 1;
      end
      if (busy && !done && !debug_on) glitch++;
      if (busy2 && !done2 && !debug_on2) glitch2++;
    end
  end

  task automatic pulse_start(input int which);
    if (which == 1) dump_start = 1'b1;
    else            start2 = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    start2     = 1'b0;
  endtask

  task automatic wait_bytes(input int base, input int want, input string nm);
    int c = 0;
    while ((n_bytes - base) < want && c < 3000) begin @(negedge clk); c++; end
    check((n_bytes - base) >= want, nm, 32'(n_bytes - base), 32'(want));
  endtask

  task automatic wait_done(input int which, input int d0, input string nm);
    int c = 0;
    while (((which == 1) ? n_done : n_done2) == d0 && c < 4000) begin @(negedge clk); c++; end
    check(((which == 1) ? n_done : n_done2) > d0, nm, 32'(c), 4000);
  endtask

  task automatic full_dump(input int which, input string nm);
    int b0, d0;
    b0 = (which == 1) ? n_bytes : n_bytes2;
    d0 = (which == 1) ? n_done : n_done2;
    push_dump(32, 0, which);
    pulse_start(which);
    wait_done(which, d0, nm);
    repeat (20) @(negedge clk);
    check((((which == 1) ? n_bytes : n_bytes2) - b0) == 128, "byte_count",
          32'(((which == 1) ? n_bytes : n_bytes2) - b0), 128);
    check((((which == 1) ? n_done : n_done2) - d0) == 1, "done_count",
          32'(((which == 1) ? n_done : n_done2) - d0), 1);
  endtask

  initial begin
    int b0, d0;
    rst = 1'b1; dump_start = 1'b0; dump_abort = 1'b0; start2 = 1'b0;
    abort2 = 1'b0; kick = 1'b0; stretch = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check(busy == 1'b0, "rst_busy", 32'(busy), 0);
    check(debug_on == 1'b0, "rst_debug_on", 32'(debug_on), 0);
    check(tx_start == 1'b0, "rst_tx_start", 32'(tx_start), 0);
    check(done == 1'b0, "rst_done", 32'(done), 0);
    check(tx_data == 8'h00, "rst_tx_data", 32'(tx_data), 0);
    check(read_regDebug == 5'd0, "rst_addr", 32'(read_regDebug), 0);
    check(busy2 == 1'b0, "rst_busy2", 32'(busy2), 0);
    rst = 1'b1;
    @(negedge clk);

    // Start and abort together in IDLE: abort wins.
    dump_start = 1'b1; dump_abort = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; dump_abort = 1'b0;
    check(busy == 1'b0, "start_abort_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);

    full_dump(1, "dump_done");

    // Spurious tx_done in IDLE/SEND and dump_start while busy.
    stretch = 1'b1;
    repeat (3) begin kick = 1'b1; @(negedge clk); kick = 1'b0; @(negedge clk); end
    b0 = n_bytes; d0 = n_done;
    push_dump(32, 0, 1);
    pulse_start(1);
    repeat (4) begin
      repeat (97) @(negedge clk);
      dump_start = 1'b1; @(negedge clk); dump_start = 1'b0;
    end
    wait_done(1, d0, "extra_done");
    repeat (20) @(negedge clk);
    stretch = 1'b0;
    check((n_bytes - b0) == 128, "extra_byte_count", 32'(n_bytes - b0), 128);
    check((n_done - d0) == 1, "extra_done_count", 32'(n_done - d0), 1);

    full_dump(2, "lat2_done");

    // Abort in WAIT_TX of reg 3, byte 2.
    b0 = n_bytes; d0 = n_done;
    push_dump(3, 3, 1);
    pulse_start(1);
    wait_bytes(b0, 15, "abort_reach");
    repeat (3) @(negedge clk);
    dump_abort = 1'b1;
    @(negedge clk);
    dump_abort = 1'b0;
    check(busy == 1'b0, "abort_busy", 32'(busy), 0);
    check(debug_on == 1'b0, "abort_debug_on", 32'(debug_on), 0);
    check(tx_start == 1'b0, "abort_tx_start", 32'(tx_start), 0);
    check(done == 1'b0, "abort_done", 32'(done), 0);
    repeat (40) @(negedge clk);
    check((n_bytes - b0) == 15, "abort_bytes", 32'(n_bytes - b0), 15);
    check(n_done == d0, "abort_no_done", 32'(n_done - d0), 0);
    full_dump(1, "restart_done");

    // Asynchronous reset during reg 10.
    b0 = n_bytes;
    push_dump(10, 1, 1);
    pulse_start(1);
    wait_bytes(b0, 41, "reset_reach");
    #2 rst = 1'b0;
    #1;
    check(busy == 1'b0, "mid_rst_busy", 32'(busy), 0);
    check(debug_on == 1'b0, "mid_rst_debug_on", 32'(debug_on), 0);
    check(tx_start == 1'b0, "mid_rst_tx_start", 32'(tx_start), 0);
    check(done == 1'b0, "mid_rst_done", 32'(done), 0);
    check(tx_data == 8'h00, "mid_rst_tx_data", 32'(tx_data), 0);
    check(read_regDebug == 5'd0, "mid_rst_addr", 32'(read_regDebug), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check(busy == 1'b0, "post_rst_idle", 32'(busy), 0);
    check((n_bytes - b0) == 41, "post_rst_bytes", 32'(n_bytes - b0), 41);

    check(q1.size() == 0, "q1_drained", 32'(q1.size()), 0);
    check(q2.size() == 0, "q2_drained", 32'(q2.size()), 0);
    check(glitch == 0, "debug_on_glitch", 32'(glitch), 0);
    check(glitch2 == 0, "debug_on2_glitch", 32'(glitch2), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
